// File: rtl/fdce_pkg.sv
// Shared constants and helpers for the FDCE-style register cell and its wrapper.
// Optional simulation checks are enabled in the wrapper with FDCE_ASSERT_EN.
package fdce_pkg;

    localparam int   FDCE_MAX_WIDTH    = 64;
    localparam logic FDCE_INIT_DEFAULT = 1'b0;
    localparam logic FDCE_INV_DEFAULT  = 1'b0;

    typedef logic [FDCE_MAX_WIDTH-1:0] fdce_word_t;

    // Applies an optional pin inversion; inv is a build-time constant.
    function automatic logic fdce_pol(input logic sig, input logic inv);
        return sig ^ inv;
    endfunction

endpackage

// File: rtl/fdce_if.sv
// Data-side bundle of the FDCE wrapper: clock enable, data in, registered data out.
// There is no valid/ready pair: CE alone qualifies a capture at the active C edge.
interface fdce_if #(
    parameter int WIDTH = 1
);
    logic             CE;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;

    modport master (output CE, output D, input Q);
    modport slave  (input CE, input D, output Q);
endinterface

// File: rtl/fdce_bit.sv
// Single-bit async-clear flop with clock enable and per-pin polarity options.
module fdce_bit
    import fdce_pkg::*;
#(
    parameter logic INIT            = FDCE_INIT_DEFAULT,
    parameter logic IS_C_INVERTED   = FDCE_INV_DEFAULT,
    parameter logic IS_CLR_INVERTED = FDCE_INV_DEFAULT,
    parameter logic IS_D_INVERTED   = FDCE_INV_DEFAULT
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic ce_i,
    input  logic d_i,
    output logic q_o
);

    logic clr_act;
    logic q_d;
    // Power-up value only; the clear always forces zero regardless of INIT.
    logic q_q = INIT;

    assign clr_act = fdce_pol(clr_i, IS_CLR_INVERTED);
    assign q_d     = ce_i ? fdce_pol(d_i, IS_D_INVERTED) : q_q;

    generate
        if (IS_C_INVERTED) begin : g_fall
            always_ff @(negedge clk_i or posedge clr_act) begin
                if (clr_act) q_q <= 1'b0;
                else         q_q <= q_d;
            end
        end else begin : g_rise
            always_ff @(posedge clk_i or posedge clr_act) begin
                if (clr_act) q_q <= 1'b0;
                else         q_q <= q_d;
            end
        end
    endgenerate

    assign q_o = q_q;

endmodule

// File: rtl/fdce_ff_wrapper.sv
// WIDTH-bit FDCE-style register built from independent fdce_bit cells.
// Define FDCE_ASSERT_EN to compile in simulation-only X/Z and CLR-release checks.
module fdce_ff_wrapper
    import fdce_pkg::*;
#(
    parameter int               WIDTH           = 1,
    parameter logic [WIDTH-1:0] INIT            = '0,
    parameter logic             IS_C_INVERTED   = FDCE_INV_DEFAULT,
    parameter logic             IS_CLR_INVERTED = FDCE_INV_DEFAULT,
    parameter logic [WIDTH-1:0] IS_D_INVERTED   = '0
) (
    input  logic        C,
    input  logic        CLR,
    fdce_if.slave       bus
);

    logic [WIDTH-1:0] q_w;

    generate
        if (WIDTH < 1 || WIDTH > FDCE_MAX_WIDTH) begin : g_bad_width
            $error("fdce_ff_wrapper: WIDTH %0d outside 1..%0d", WIDTH, FDCE_MAX_WIDTH);
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            fdce_bit #(
                .INIT            (INIT[i]),
                .IS_C_INVERTED   (IS_C_INVERTED),
                .IS_CLR_INVERTED (IS_CLR_INVERTED),
                .IS_D_INVERTED   (IS_D_INVERTED[i])
            ) u_bit (
                .clk_i (C),
                .clr_i (CLR),
                .ce_i  (bus.CE),
                .d_i   (bus.D[i]),
                .q_o   (q_w[i])
            );
        end
    endgenerate

    assign bus.Q = q_w;

`ifdef FDCE_ASSERT_EN
    logic c_act;
    logic clr_act;
    time  edge_t;
    time  rel_t;

    assign c_act   = C ^ IS_C_INVERTED;
    assign clr_act = fdce_pol(CLR, IS_CLR_INVERTED);

    always @(posedge c_act) begin
        edge_t = $time;
        assert (!$isunknown({bus.CE, CLR, bus.D}))
            else $error("fdce_ff_wrapper: X/Z on CE/CLR/D at active edge, t=%0t", $time);
        if (rel_t == $time)
            $warning("fdce_ff_wrapper: CLR released in the same timestep as an active edge");
    end

    always @(negedge clr_act) begin
        rel_t = $time;
        if (edge_t == $time)
            $warning("fdce_ff_wrapper: CLR released in the same timestep as an active edge");
    end

    always @(CLR) begin
        assert (!$isunknown(CLR)) else $error("fdce_ff_wrapper: CLR is X/Z, t=%0t", $time);
    end
`else
    // Default build: no simulation checks; synthesised logic is the same either way.
`endif

endmodule

// File: tb/tb_fdce_ff_wrapper.sv
// Directed bench for fdce_ff_wrapper: toggle divider, async clear, CE hold,
// 8-bit vector with INIT, and a fully inverted-pin 4-bit variant.
module tb_fdce_ff_wrapper;

  logic C     = 1'b0;
  logic clr_a = 1'b0;
  logic clr_b = 1'b0;
  logic clr_c = 1'b1;  // active-low clear on the inverted variant

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic       exp_a;
  logic [7:0] v;
  logic [3:0] dc;

  fdce_if #(.WIDTH(1)) if_a ();
  fdce_if #(.WIDTH(8)) if_b ();
  fdce_if #(.WIDTH(4)) if_c ();

  // Divide-by-2 feedback on the default build.
  assign if_a.D = ~if_a.Q;

  fdce_ff_wrapper u_dut_a (
    .C   (C),
    .CLR (clr_a),
    .bus (if_a)
  );

  fdce_ff_wrapper #(
    .WIDTH (8),
    .INIT  (8'hA5)
  ) u_dut_b (
    .C   (C),
    .CLR (clr_b),
    .bus (if_b)
  );

  fdce_ff_wrapper #(
    .WIDTH           (4),
    .IS_C_INVERTED   (1'b1),
    .IS_CLR_INVERTED (1'b1),
    .IS_D_INVERTED   (4'hF)
  ) u_dut_c (
    .C   (C),
    .CLR (clr_c),
    .bus (if_c)
  );

  // 8 ns clock
  always #4 C = ~C;

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0h, scoreboard empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp)
        else begin
          n_fail++;
          $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    end
  endtask

  initial begin
    if_a.CE = 1'b0;
    if_b.CE = 1'b0;
    if_b.D  = 8'h00;
    if_c.CE = 1'b0;
    if_c.D  = 4'h0;
    exp_a   = 1'b0;

    // Power-up values
    #1;
    exp_q.push_back(8'h00); check("a_init", {7'h0, if_a.Q});
    exp_q.push_back(8'hA5); check("b_init", if_b.Q);
    exp_q.push_back(8'h00); check("c_init", {4'h0, if_c.Q});

    // Toggle divider: odd count leaves Q=1 for the clear test
    if_a.CE = 1'b1;
    for (int i = 0; i < 201; i++) begin
      exp_a = ~exp_a;
      exp_q.push_back({7'h0, exp_a});
      @(posedge C); #1;
      check("a_toggle", {7'h0, if_a.Q});
    end

    // 3 ns clear pulse between edges
    #1 clr_a = 1'b1;
    #1;
    exp_a = 1'b0;
    exp_q.push_back(8'h00); check("a_clr_async", {7'h0, if_a.Q});
    #2 clr_a = 1'b0;
    #1;
    exp_q.push_back(8'h00); check("a_clr_released", {7'h0, if_a.Q});
    exp_a = 1'b1;
    exp_q.push_back({7'h0, exp_a});
    @(posedge C); #1;
    check("a_first_after_clr", {7'h0, if_a.Q});

    // CE low for 5 edges
    if_a.CE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({7'h0, exp_a});
      @(posedge C); #1;
      check("a_ce_hold", {7'h0, if_a.Q});
    end

    // CE glitch between edges is ignored
    #2 if_a.CE = 1'b1;
    #1 if_a.CE = 1'b0;
    exp_q.push_back({7'h0, exp_a});
    @(posedge C); #1;
    check("a_ce_glitch", {7'h0, if_a.Q});

    if_a.CE = 1'b1;
    exp_a = ~exp_a;
    exp_q.push_back({7'h0, exp_a});
    @(posedge C); #1;
    check("a_ce_resume", {7'h0, if_a.Q});

    // Clear held across an enabled edge
    clr_a = 1'b1;
    #1;
    exp_a = 1'b0;
    exp_q.push_back(8'h00); check("a_clr_set", {7'h0, if_a.Q});
    exp_q.push_back(8'h00);
    @(posedge C); #1;
    check("a_clr_over_edge", {7'h0, if_a.Q});
    clr_a = 1'b0;
    exp_a = 1'b1;
    exp_q.push_back({7'h0, exp_a});
    @(posedge C); #1;
    check("a_after_clr_edge", {7'h0, if_a.Q});

    // 8-bit vector: clear, load, random loads, hold
    clr_b = 1'b1;
    #1;
    exp_q.push_back(8'h00); check("b_clr", if_b.Q);
    clr_b = 1'b0;
    if_b.D  = 8'h3C;
    if_b.CE = 1'b1;
    exp_q.push_back(8'h3C);
    @(posedge C); #1;
    check("b_load", if_b.Q);
    for (int i = 0; i < 4; i++) begin
      v = 8'($urandom_range(0, 255));
      if_b.D = v;
      exp_q.push_back(v);
      @(posedge C); #1;
      check("b_rand", if_b.Q);
    end
    if_b.CE = 1'b0;
    if_b.D  = ~v;
    exp_q.push_back(v);
    @(posedge C); #1;
    check("b_ce_hold", if_b.Q);

    // Inverted variant: falling-edge capture, inverted D, active-low clear
    @(negedge C); #1;
    if_c.D  = 4'h6;
    if_c.CE = 1'b1;
    exp_q.push_back(8'h00);
    @(posedge C); #1;
    check("c_no_rise_capture", {4'h0, if_c.Q});
    exp_q.push_back(8'h09);
    @(negedge C); #1;
    check("c_fall_capture", {4'h0, if_c.Q});
    dc = 4'($urandom_range(0, 15));
    if_c.D = dc;
    exp_q.push_back({4'h0, ~dc});
    @(negedge C); #1;
    check("c_fall_rand", {4'h0, if_c.Q});
    clr_c = 1'b0;
    #1;
    exp_q.push_back(8'h00); check("c_clr_low", {4'h0, if_c.Q});
    clr_c = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
